// File: rtl/pycpu_bus_pkg.sv
// rtl/pycpu_bus_pkg.sv - shared constants and helpers for the pycpu bus arbiter
package pycpu_bus_pkg;

  typedef logic [1:0] bus_state_t;

  localparam bus_state_t ST_IDLE   = 2'd0;
  localparam bus_state_t ST_ACCESS = 2'd1;
  localparam bus_state_t ST_ACK    = 2'd2;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return (idx == M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pycpu_rr_arb2.sv
// rtl/pycpu_rr_arb2.sv - two-way round-robin picker with lock-owner masking
module pycpu_rr_arb2
  import pycpu_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       owner_vld_i,
  input  logic       owner_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o,
  output logic       gnt_vld_o
);

  logic [1:0] elig;

  always_comb begin
    elig = req_i;
    // A held lock hides the non-owner entirely, even if it is favoured.
    if (owner_vld_i) begin
      elig = req_i & idx_to_onehot(owner_i);
    end

    gnt_idx_o = ptr_i;
    gnt_vld_o = 1'b0;
    if (elig[ptr_i]) begin
      gnt_idx_o = ptr_i;
      gnt_vld_o = 1'b1;
    end else if (elig[~ptr_i]) begin
      gnt_idx_o = ~ptr_i;
      gnt_vld_o = 1'b1;
    end

    gnt_o = gnt_vld_o ? idx_to_onehot(gnt_idx_o) : 2'b00;
  end

endmodule

// File: rtl/pycpu_bus_arbiter.sv
// rtl/pycpu_bus_arbiter.sv - two-master arbiter and access sequencer for the external bus
module pycpu_bus_arbiter
  import pycpu_bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_m0_req,
  input  logic              i_m0_rw,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic              i_m0_lock,
  output logic              o_m0_ack,
  input  logic              i_m1_req,
  input  logic              i_m1_rw,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic              i_m1_lock,
  output logic              o_m1_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_gnt,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_rw,
  output logic              o_oe,
  output logic              o_lock,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_busy
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  bus_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              gidx_q, gidx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic              lock_q, lock_d;
  logic              owner_vld_q, owner_vld_d;
  logic              owner_q, owner_d;
  logic              ptr_q, ptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        arb_gnt;
  logic              arb_idx;
  logic              arb_vld;

  pycpu_rr_arb2 u_arb (
    .req_i       ({i_m1_req, i_m0_req}),
    .ptr_i       (ptr_q),
    .owner_vld_i (owner_vld_q),
    .owner_i     (owner_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_vld_o   (arb_vld)
  );

  // The latch source is the fresh arbitration winner in IDLE, or the current
  // grantee when a locked sequence is re-granted straight out of ACK.
  logic              lat_idx;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_rw;
  logic              lat_lock;
  logic              gidx_req;

  assign lat_idx   = (state_q == ST_ACK) ? gidx_q : arb_idx;
  assign lat_addr  = (lat_idx == M1) ? i_m1_addr  : i_m0_addr;
  assign lat_wdata = (lat_idx == M1) ? i_m1_wdata : i_m0_wdata;
  assign lat_rw    = (lat_idx == M1) ? i_m1_rw    : i_m0_rw;
  assign lat_lock  = (lat_idx == M1) ? i_m1_lock  : i_m0_lock;
  assign gidx_req  = (gidx_q == M1) ? i_m1_req : i_m0_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    lock_d      = lock_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          state_d = ST_ACCESS;
          gnt_d   = arb_gnt;
          gidx_d  = arb_idx;
          addr_d  = lat_addr;
          wdata_d = lat_wdata;
          rw_d    = lat_rw;
          lock_d  = lat_lock;
          cnt_d   = WAIT_CNT;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          if (rw_q == RW_READ) begin
            rdata_d = i_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_ACK: begin
        owner_vld_d = lock_q;
        owner_d     = gidx_q;
        ptr_d       = ~gidx_q;
        if (lock_q && gidx_req) begin
          state_d = ST_ACCESS;
          addr_d  = lat_addr;
          wdata_d = lat_wdata;
          rw_d    = lat_rw;
          lock_d  = lat_lock;
          cnt_d   = WAIT_CNT;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      gnt_q       <= 2'b00;
      gidx_q      <= M0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= RW_READ;
      lock_q      <= 1'b0;
      owner_vld_q <= 1'b0;
      owner_q     <= M0;
      ptr_q       <= M0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      lock_q      <= lock_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      rdata_q     <= rdata_d;
    end
  end

  logic in_access;
  logic in_ack;

  assign in_access = (state_q == ST_ACCESS);
  assign in_ack    = (state_q == ST_ACK);

  assign o_busy   = (state_q != ST_IDLE);
  assign o_gnt    = gnt_q;
  assign o_addr   = addr_q;
  assign o_rw     = in_access & (rw_q == RW_WRITE);
  assign o_oe     = in_access & (rw_q == RW_WRITE);
  assign o_wdata  = o_oe ? wdata_q : '0;
  assign o_rdata  = rdata_q;
  assign o_m0_ack = in_ack & (gidx_q == M0);
  assign o_m1_ack = in_ack & (gidx_q == M1);
  // Lock stays visible through the ack of a locking access so the RMW window has no gap.
  assign o_lock   = owner_vld_q | (o_busy & lock_q);

endmodule

// File: tb/tb_pycpu_bus_arbiter.sv
// tb/tb_pycpu_bus_arbiter.sv - self-checking bench for pycpu_bus_arbiter
module tb_pycpu_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req [2];
  logic          rw  [2];
  logic          lk  [2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wd  [2];
  logic [DW-1:0] bus_rdata;

  logic          ack0, ack1, o_rw, o_oe, o_lock, busy;
  logic [DW-1:0] rdata, o_wdata;
  logic [AW-1:0] o_addr;
  logic [1:0]    gnt;

  pycpu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .i_m0_req(req[0]), .i_m0_rw(rw[0]), .i_m0_addr(addr[0]), .i_m0_wdata(wd[0]), .i_m0_lock(lk[0]),
    .o_m0_ack(ack0),
    .i_m1_req(req[1]), .i_m1_rw(rw[1]), .i_m1_addr(addr[1]), .i_m1_wdata(wd[1]), .i_m1_lock(lk[1]),
    .o_m1_ack(ack1),
    .o_rdata(rdata), .o_gnt(gnt), .o_addr(o_addr), .o_wdata(o_wdata), .o_rw(o_rw), .o_oe(o_oe),
    .o_lock(o_lock), .i_rdata(bus_rdata), .o_busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Transaction-level model: a grant starts a step count; steps 1..W+1 are the
  // bus phase, step W+2 is the ack.
  bit            m_active;
  int            m_k, m_who, m_owner, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  bit            m_rw, m_lock;

  task automatic model_reset();
    m_active = 0; m_k = 0; m_who = 0; m_owner = -1; m_last = -1;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_rw = 0; m_lock = 0;
  endtask

  function automatic bit eligible(int i);
    return req[i] && (m_owner < 0 || m_owner == i);
  endfunction

  task automatic model_latch(int i);
    m_who = i; m_addr = addr[i]; m_wdata = wd[i]; m_rw = rw[i]; m_lock = lk[i];
    m_active = 1; m_k = 1;
  endtask

  task automatic model_step();
    int fav;
    if (rst) begin
      model_reset();
    end else if (!m_active) begin
      fav = (m_last == 0) ? 1 : 0;
      if (eligible(fav)) model_latch(fav);
      else if (eligible(1 - fav)) model_latch(1 - fav);
    end else if (m_k <= W + 1) begin
      if (m_k == W + 1 && !m_rw) m_rdata = bus_rdata;
      m_k++;
    end else begin
      m_last  = m_who;
      m_owner = m_lock ? m_who : -1;
      if (m_lock && req[m_who]) model_latch(m_who);
      else m_active = 0;
    end
  endtask

  task automatic compare();
    bit       acc, ak, bad;
    logic [1:0] e_gnt;
    logic       e_lock;
    acc    = m_active && (m_k <= W + 1);
    ak     = m_active && (m_k == W + 2);
    e_gnt  = !m_active ? 2'b00 : (m_who == 1 ? 2'b10 : 2'b01);
    e_lock = (m_owner >= 0) || (m_active && m_lock);
    bad = (ack0 !== (ak && m_who == 0)) || (ack1 !== (ak && m_who == 1)) ||
          (gnt !== e_gnt) || (busy !== m_active) || (o_lock !== e_lock) ||
          (rdata !== m_rdata) || (o_oe !== (acc && m_rw));
    if (acc && (o_rw !== m_rw)) bad = 1;
    if (m_active && (o_addr !== m_addr)) bad = 1;
    if (acc && m_rw && (o_wdata !== m_wdata)) bad = 1;
    n_chk++;
    if (bad)
      $display("FAIL model cyc=%0d act ack=%b%b gnt=%b busy=%b lock=%b oe=%b rw=%b addr=%h wd=%h rd=%h exp ack=%b%b gnt=%b busy=%b lock=%b oe=%b rw=%b addr=%h wd=%h rd=%h",
               cyc, ack1, ack0, gnt, busy, o_lock, o_oe, o_rw, o_addr, o_wdata, rdata,
               ak && m_who == 1, ak && m_who == 0, e_gnt, m_active, e_lock, acc && m_rw, m_rw,
               m_addr, m_wdata, m_rdata);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_req(int i, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] d, bit l);
    req[i] = r; rw[i] = w; addr[i] = a; wd[i] = d; lk[i] = l;
  endtask

  function automatic bit acked(int i);
    return (i == 0) ? ack0 : ack1;
  endfunction

  int pend[2];

  task automatic new_req(int i);
    set_req(i, 1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 0);
    if (!rw[i] && $urandom_range(0, 4) == 0) lk[i] = 1;
  endtask

  initial begin
    int n, cnt, acks, oe_seen, lock_low, t1, t2, nord;
    int ord[4];
    int rem[2];
    bit in_rmw;

    rst = 1; bus_rdata = '0;
    for (int i = 0; i < 2; i++) begin set_req(i, 0, 0, '0, '0, 0); pend[i] = 0; end
    model_reset();
    repeat (3) tick();
    rst = 0;
    chk("reset_outputs", {27'd0, ack0, ack1, busy, o_oe, o_lock}, 32'd0);
    chk("reset_gnt_addr_rdata", {gnt, o_addr, rdata[13:0]}, 32'd0);

    // Single read by m0.
    set_req(0, 1, 0, 16'h0010, 16'h0, 0); bus_rdata = 16'hBEEF;
    n = -1; oe_seen = 0; cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (o_oe) oe_seen = 1;
      if (busy && !ack0 && o_addr == 16'h0010) cnt++;
      if (ack0) begin n = c; break; end
    end
    req[0] = 0;
    chk("rd_latency", n, W + 2);
    chk("rd_rdata", rdata, 16'hBEEF);
    chk("rd_oe_low", oe_seen, 0);
    chk("rd_addr_cycles", cnt, W + 1);
    tick();

    // Single write by m1.
    set_req(1, 1, 1, 16'h00F0, 16'h1234, 0); bus_rdata = 16'h5555;
    cnt = 0; acks = 0;
    for (int c = 1; c <= W + 8; c++) begin
      tick();
      if (o_oe && o_rw && o_wdata == 16'h1234 && o_addr == 16'h00F0) cnt++;
      if (ack1) begin acks++; req[1] = 0; end
    end
    chk("wr_drive_cycles", cnt, W + 1);
    chk("wr_ack_pulses", acks, 1);
    chk("wr_rdata_kept", rdata, 16'hBEEF);

    // Contention: both hold requests for two accesses each.
    rem[0] = 2; rem[1] = 2; nord = 0;
    for (int k = 0; k < 4; k++) ord[k] = -1;
    set_req(0, 1, 0, 16'h0100, 16'h0, 0);
    set_req(1, 1, 0, 16'h0200, 16'h0, 0);
    for (int c = 1; c <= 200 && nord < 4; c++) begin
      tick();
      for (int i = 0; i < 2; i++) if (acked(i)) begin
        if (nord < 4) ord[nord] = i;
        nord++; rem[i]--;
        if (rem[i] == 0) req[i] = 0; else addr[i] = addr[i] + 16'd1;
      end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("rr_order_%0d", k), ord[k], k % 2);
    repeat (2) tick();

    // Locked RMW by m1 while m0 waits.
    set_req(1, 1, 0, 16'h0040, 16'h0, 1);
    tick();
    set_req(0, 1, 0, 16'h0080, 16'h0, 0);
    nord = 0; lock_low = 0; t1 = -1; t2 = -1; in_rmw = 1;
    for (int k = 0; k < 4; k++) ord[k] = -1;
    if (!o_lock) lock_low++;
    for (int c = 1; c <= 200 && nord < 3; c++) begin
      tick();
      if (in_rmw && !o_lock) lock_low++;
      if (t1 >= 0 && c == t1 + 1) chk("rmw_b2b_write", {gnt, busy, o_oe}, 4'b1011);
      for (int i = 0; i < 2; i++) if (acked(i)) begin
        if (nord < 4) ord[nord] = i;
        nord++;
        if (i == 1 && t1 < 0) begin t1 = c; set_req(1, 1, 1, 16'h0040, 16'hA5A5, 0); end
        else if (i == 1) begin t2 = c; req[1] = 0; in_rmw = 0; end
        else req[0] = 0;
      end
    end
    chk("rmw_order", {ord[0][7:0], ord[1][7:0], ord[2][7:0]}, 24'h010100);
    chk("rmw_gap", t2 - t1, W + 2);
    chk("rmw_lock_held", lock_low, 0);
    repeat (2) tick();

    // Reset during the bus phase.
    set_req(0, 1, 0, 16'h0022, 16'h0, 0); bus_rdata = 16'h7777;
    tick();
    if (W >= 1) tick();
    rst = 1; req[0] = 0;
    tick();
    rst = 0;
    chk("rst_mid_flags", {ack0, ack1, busy, o_oe, o_lock, gnt}, 7'd0);
    chk("rst_mid_data", {o_addr, rdata}, 32'd0);
    set_req(0, 1, 0, 16'h0033, 16'h0, 0); bus_rdata = 16'hC0DE;
    n = -1;
    for (int c = 1; c <= 40; c++) begin tick(); if (ack0) begin n = c; break; end end
    req[0] = 0;
    chk("post_rst_latency", n, W + 2);
    chk("post_rst_rdata", rdata, 16'hC0DE);
    tick();

    // Randomized traffic with locked sequences and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus_rdata = DW'($urandom);
      if (rst) rst = 0;
      for (int i = 0; i < 2; i++) begin
        if (acked(i)) begin
          if (lk[i]) begin
            set_req(i, 1, 1, addr[i], DW'($urandom), 0);
            pend[i] = $urandom_range(0, 2);
            if (pend[i] != 0) req[i] = 0;
          end else if ($urandom_range(0, 3) == 0) new_req(i);
          else req[i] = 0;
        end else if (!req[i]) begin
          if (pend[i] > 0) begin
            pend[i]--;
            if (pend[i] == 0) req[i] = 1;
          end else if ($urandom_range(0, 2) == 0) new_req(i);
        end
      end
      if ($urandom_range(0, 399) == 0) begin
        rst = 1;
        for (int i = 0; i < 2; i++) begin req[i] = 0; lk[i] = 0; pend[i] = 0; end
      end
    end
    rst = 0;
    for (int i = 0; i < 2; i++) begin req[i] = 0; lk[i] = 0; pend[i] = 0; end
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    chk("drain_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
